boa_stage_mem: RTL
==================

# boa_stage_mem

Boa³² pipeline stage MEM: consumes the EX/MEM barrier and performs LOAD/STORE accesses on a single-port data bus with a wait-state handshake. It produces the MEM/WB barrier. Every non-memory instruction passes through with its ALU result; load data is byte/halfword-extracted and extended. The stage raises misalignment and access-fault traps, requests pipeline stalls while a bus access is outstanding, and provides a forwarding output.

## Interface
- No parameters.
- clk  in  1  CPU clock.
- rst  in  1  Reset, synchronous, active-high.
- clear  in  1  Invalidate results and clear traps.
- d_valid, d_pc[31:1], d_insn[31:0], d_use_rd  in  1/31/32/1  EX/MEM: valid, PC, instruction word, writes RD.
- d_rs1_val  in  32  EX/MEM: ALU result / memory address.
- d_rs2_val  in  32  EX/MEM: store data.
- d_trap, d_cause  in  1/4  EX/MEM: trap raised, cause.
- q_valid, q_pc, q_insn, q_use_rd  out  1/31/32/1  MEM/WB copies.
- q_rd_val  out  32  MEM/WB: RD write value.
- q_trap, q_cause  out  1/4  MEM/WB trap, cause.
- bus_re  out  1  Read request.
- bus_we  out  4  Byte write strobes; nonzero means write request.
- bus_addr  out  30  Word address [31:2].
- bus_wdata  out  32  Write data.
- bus_ready  in  1  Access completes this cycle. rdata is valid in the same cycle.
- bus_err  in  1  Qualifies bus_ready: access fault.
- bus_rdata  in  32  Read data.
- stall_req  out  1  MEM needs more cycles; hazard unit holds EX and earlier.
- fw_stall_mem  in  1  Hold MEM stage (downstream stall).
- fw_rs2, fw_in  in  1/32  Forward fw_in over d_rs2_val for store data.
- fw_rd, fw_out  out  1/32  Forwardable result valid, value.

## Operation
- Access needed when d_valid && opcode LOAD/STORE && !d_trap && aligned && !clear.
- Alignment by funct3[1:0]:
  - Byte accesses are always aligned.
  - Halfword requires addr[0]=0.
  - Word requires addr[1:0]=0.
- Misaligned access:
  - No bus request.
  - Load gives trap cause 4; store gives cause 6.
- Bus error on ready gives cause 5 (load) or 7 (store). An incoming d_trap passes unchanged.
- Store strobes and data:
  - SB: bus_we=0001<<addr[1:0], data byte replicated ×4.
  - SH: bus_we=0011<<addr[1:0], halfword replicated ×2.
  - SW: bus_we=1111.
- Load extraction:
  - LB/LBU select the byte at addr[1:0], sign/zero extended.
  - LH/LHU select the half at addr[1], sign/zero extended.
  - LW takes the full word.
- q_rd_val: extracted load data for LOAD, otherwise d_rs1_val.
- States:
  - IDLE: if access needed, drive request. bus_ready goes to DONE handling; otherwise go to BUSY.
  - BUSY: drive request (address, strobes, data stable). Go to DONE handling on bus_ready.
  - DONE handling: if fw_stall_mem, latch extracted data/fault into a hold register and go to HOLD; else commit to barrier and go to IDLE.
  - HOLD: no request. When !fw_stall_mem, commit the held result and go to IDLE.
- stall_req = (access needed in IDLE, or in BUSY) && !bus_ready.
- Barrier commit conditions:
  - !fw_stall_mem && !stall_req: update all q_*.
  - !fw_stall_mem && stall_req: q_valid←0, q_trap←0 (bubble).
  - fw_stall_mem: hold all q_*.
- clear:
  - q_valid←0 and q_trap←0 at the next edge.
  - No new request is issued.
  - An outstanding BUSY request stays asserted until bus_ready. Its result is discarded, then the stage returns to IDLE.
- fw_rd = d_valid && d_use_rd && !d_trap && (!LOAD || load completing this cycle || HOLD).
- fw_out is the same value committed to q_rd_val.

## Timing
- Reset values:
  - Outputs: q_valid=0, q_trap=0; all other q_* = 0.
  - State: IDLE.
  - Bus outputs: bus_re=0, bus_we=0 (combinational, gated by state).
- Request outputs are combinational from d_* and state. There is no registered request delay.
- Zero-wait access:
  - Request in cycle N with bus_ready=1.
  - q_* valid after edge N.
  - stall_req never asserted.
- k wait states: stall_req high for k cycles, and q_valid=0 after each of those edges.
- Reset mid-BUSY: state→IDLE immediately. The bus master tolerates dropped requests after reset.
- Simultaneous bus_ready and fw_stall_mem: data is latched into HOLD; the bus is not re-requested.

## Test plan
- LW at addr 0x100, bus_ready=1 same cycle, rdata=0xDEADBEEF:
  - bus_re=1, bus_addr=0x40.
  - Next cycle q_rd_val=0xDEADBEEF, q_valid=1, stall_req=0.
- LB at 0x103, rdata=0x80123456 → q_rd_val=0xFFFFFF80. LBU at the same address → 0x00000080. LHU at 0x102 → 0x00008012.
- SH at 0x101 → no request, q_trap=1, q_cause=6. SB at 0x102 with data 0xAB → bus_we=0100, bus_wdata=0xABABABAB.
- LW with 3 wait states:
  - stall_req high 3 cycles, q_valid=0 on those edges.
  - Request fields stable.
  - bus_ready on cycle 4 commits data.
- bus_ready with fw_stall_mem=1 for 2 cycles:
  - No re-request.
  - q held for those 2 cycles, then the latched data commits.
- clear asserted during BUSY:
  - Request held until bus_ready.
  - q_valid=0, q_trap=0.
  - Then IDLE, with no write-back of that load.

Source files
------------

// File: rtl/boa_stage_mem.sv
// Boa32 MEM stage: turns EX/MEM into MEM/WB, running LOAD/STORE accesses on a
// single-port wait-state bus, with alignment/fault traps, stall requests and forwarding.
module boa_stage_mem (
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        d_valid,
   input  logic [31:1] d_pc,
   input  logic [31:0] d_insn,
   input  logic        d_use_rd,
   input  logic [31:0] d_rs1_val,
   input  logic [31:0] d_rs2_val,
   input  logic        d_trap,
   input  logic [3:0]  d_cause,
   output logic        q_valid,
   output logic [31:1] q_pc,
   output logic [31:0] q_insn,
   output logic        q_use_rd,
   output logic [31:0] q_rd_val,
   output logic        q_trap,
   output logic [3:0]  q_cause,
   output logic        bus_re,
   output logic [3:0]  bus_we,
   output logic [29:0] bus_addr,
   output logic [31:0] bus_wdata,
   input  logic        bus_ready,
   input  logic        bus_err,
   input  logic [31:0] bus_rdata,
   output logic        stall_req,
   input  logic        fw_stall_mem,
   input  logic        fw_rs2,
   input  logic [31:0] fw_in,
   output logic        fw_rd,
   output logic [31:0] fw_out
);
   typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

   state_t      state;
   logic        drop;
   logic        hold_fault;
   logic [31:0] hold_val;

   logic [2:0]  f3;
   logic [1:0]  off;
   logic        is_load, is_store, aligned, misalign, need, req, done;
   logic [31:0] store_data, ld_shift, ld_data, rd_val;
   logic [15:0] ld_half;
   logic        trap_val;
   logic [3:0]  cause_val;

   always_comb begin
      f3       = d_insn[14:12];
      off      = d_rs1_val[1:0];
      is_load  = d_insn[6:0] == 7'b0000011;
      is_store = d_insn[6:0] == 7'b0100011;
      case (f3[1:0])
         2'd0:    aligned = 1'b1;
         2'd1:    aligned = !off[0];
         default: aligned = off == 2'b00;
      endcase
      misalign = d_valid && (is_load || is_store) && !d_trap && !aligned;
      need     = d_valid && (is_load || is_store) && !d_trap && aligned && !clear;
      // BUSY keeps requesting even under clear: the bus cannot abandon an access
      req       = (state == IDLE && need) || state == BUSY;
      done      = req && bus_ready;
      stall_req = req && !bus_ready;

      store_data = fw_rs2 ? fw_in : d_rs2_val;
      bus_addr   = d_rs1_val[31:2];
      bus_re     = req && is_load;
      bus_we     = 4'b0000;
      case (f3[1:0])
         2'd0:    bus_wdata = {4{store_data[7:0]}};
         2'd1:    bus_wdata = {2{store_data[15:0]}};
         default: bus_wdata = store_data;
      endcase
      if (req && is_store) begin
         case (f3[1:0])
            2'd0:    bus_we = 4'b0001 << off;
            2'd1:    bus_we = 4'b0011 << off;
            default: bus_we = 4'b1111;
         endcase
      end

      ld_shift = bus_rdata >> {off, 3'b000};
      ld_half  = off[1] ? bus_rdata[31:16] : bus_rdata[15:0];
      case (f3)
         3'b000:  ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
         3'b100:  ld_data = {24'h0, ld_shift[7:0]};
         3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
         3'b101:  ld_data = {16'h0, ld_half};
         default: ld_data = bus_rdata;
      endcase

      rd_val    = (state == HOLD) ? hold_val : (is_load ? ld_data : d_rs1_val);
      trap_val  = (state == HOLD) ? hold_fault : (d_trap || misalign || (done && bus_err));
      cause_val = d_trap ? d_cause : misalign ? (is_store ? 4'd6 : 4'd4)
                                              : (is_store ? 4'd7 : 4'd5);
      fw_rd  = d_valid && d_use_rd && !d_trap && (!is_load || done || state == HOLD);
      fw_out = rd_val;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         drop       <= 1'b0;
         hold_val   <= '0;
         hold_fault <= 1'b0;
         q_valid    <= 1'b0;
         q_pc       <= '0;
         q_insn     <= '0;
         q_use_rd   <= 1'b0;
         q_rd_val   <= '0;
         q_trap     <= 1'b0;
         q_cause    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (need && !bus_ready) state <= BUSY;
               else if (need && fw_stall_mem) begin
                  state      <= HOLD;
                  hold_val   <= rd_val;
                  hold_fault <= bus_err;
               end
            end
            BUSY: begin
               if (bus_ready) begin
                  drop <= 1'b0;
                  if (drop || clear) state <= IDLE;
                  else if (fw_stall_mem) begin
                     state      <= HOLD;
                     hold_val   <= rd_val;
                     hold_fault <= bus_err;
                  end else state <= IDLE;
               end else if (clear) drop <= 1'b1;
            end
            HOLD:    if (clear || !fw_stall_mem) state <= IDLE;
            default: state <= IDLE;
         endcase

         // a flushed access still completes on the bus, but never writes back
         if (clear || (state == BUSY && drop)) begin
            q_valid <= 1'b0;
            q_trap  <= 1'b0;
         end else if (!fw_stall_mem) begin
            if (stall_req) begin
               q_valid <= 1'b0;
               q_trap  <= 1'b0;
            end else begin
               q_valid  <= d_valid;
               q_pc     <= d_pc;
               q_insn   <= d_insn;
               q_use_rd <= d_use_rd;
               q_rd_val <= rd_val;
               q_trap   <= trap_val;
               q_cause  <= cause_val;
            end
         end
      end
   end
endmodule
